// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes, reset constants, fetch state and IF/ID payload.
package cpu_pkg;

    localparam int unsigned XLEN = 16;

    localparam logic [3:0]      OPC_HLT   = 4'hF;
    localparam logic [XLEN-1:0] NOP_INSTR = 16'h0000;
    localparam logic [XLEN-1:0] PC_RESET  = 16'h0000;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc_plus1;
        logic            valid;
    } if_id_t;

    localparam int unsigned IF_ID_W = $bits(if_id_t);

    // True when the instruction word carries the halt opcode.
    function automatic logic is_hlt(input logic [XLEN-1:0] instr);
        return instr[XLEN-1:XLEN-4] == OPC_HLT;
    endfunction

endpackage

// File: rtl/if_skid_buf.sv
// One-entry holding register; parks a response that arrives while decode is stalled.
module if_skid_buf #(
    parameter int unsigned W = 33
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         clear,
    input  logic [W-1:0] din,
    output logic         valid,
    output logic [W-1:0] dout
);

    logic         vld_q, vld_d;
    logic [W-1:0] data_q, data_d;

    // Clear wins over load so a redirect always empties the entry.
    always_comb begin
        vld_d  = vld_q;
        data_d = data_q;
        if (clear) begin
            vld_d = 1'b0;
        end else if (load) begin
            vld_d  = 1'b1;
            data_d = din;
        end
    end

    // Entry storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q  <= 1'b0;
            data_q <= '0;
        end else begin
            vld_q  <= vld_d;
            data_q <= data_d;
        end
    end

    assign valid = vld_q;
    assign dout  = data_q;

endmodule

// File: rtl/if_stage.sv
// Instruction fetch: PC, synchronous imem issue, response tracking and the IF/ID register.
module if_stage #(
    parameter logic [15:0] PC_RESET  = cpu_pkg::PC_RESET,
    parameter logic [15:0] NOP_INSTR = cpu_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic [15:0] imem_addr,
    output logic        imem_rd_en,
    input  logic [15:0] imem_rdata,
    output logic [15:0] if_id_instr,
    output logic [15:0] if_id_pc_plus1,
    output logic        if_id_valid,
    output logic [15:0] pc,
    output logic        fetch_halted
);

    import cpu_pkg::*;

    fetch_state_e      state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic              rsp_vld_q, rsp_vld_d;
    logic [XLEN-1:0]   rsp_pc_q, rsp_pc_d;
    if_id_t            if_id_q, if_id_d;

    logic              issue_c;
    if_id_t            rsp_entry_c;
    if_id_t            bubble_c;
    logic              skid_load_c;
    logic              skid_clear_c;
    logic              skid_vld;
    logic [IF_ID_W-1:0] skid_dout;

    if_skid_buf #(
        .W (IF_ID_W)
    ) u_skid (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (skid_load_c),
        .clear (skid_clear_c),
        .din   (rsp_entry_c),
        .valid (skid_vld),
        .dout  (skid_dout)
    );

    // Next-state: redirect beats stall beats normal flow; halt is taken when an HLT lands.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        rsp_vld_d    = 1'b0;
        rsp_pc_d     = rsp_pc_q;
        if_id_d      = if_id_q;
        skid_load_c  = 1'b0;
        skid_clear_c = 1'b0;

        issue_c = (state_q == RUN) && !stall && !redirect;

        rsp_entry_c.instr    = imem_rdata;
        rsp_entry_c.pc_plus1 = rsp_pc_q + 16'd1;
        rsp_entry_c.valid    = 1'b1;

        bubble_c.instr    = NOP_INSTR;
        bubble_c.pc_plus1 = '0;
        bubble_c.valid    = 1'b0;

        if (redirect) begin
            pc_d         = redirect_pc;
            if_id_d      = bubble_c;
            skid_clear_c = 1'b1;
            state_d      = RUN;
        end else if (stall) begin
            if (rsp_vld_q) begin
                skid_load_c = 1'b1;
                if (is_hlt(imem_rdata)) begin
                    state_d = HALTED;
                end
            end
        end else begin
            if (skid_vld) begin
                if_id_d      = if_id_t'(skid_dout);
                skid_clear_c = 1'b1;
            end else if (rsp_vld_q) begin
                if_id_d = rsp_entry_c;
                if (is_hlt(imem_rdata)) begin
                    state_d = HALTED;
                end
            end else begin
                if_id_d = bubble_c;
            end

            if (issue_c) begin
                pc_d      = pc_q + 16'd1;
                rsp_vld_d = 1'b1;
                rsp_pc_d  = pc_q;
            end
        end
    end

    // Pipeline and control registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= RUN;
            pc_q             <= PC_RESET;
            rsp_vld_q        <= 1'b0;
            rsp_pc_q         <= '0;
            if_id_q.instr    <= NOP_INSTR;
            if_id_q.pc_plus1 <= '0;
            if_id_q.valid    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            rsp_vld_q <= rsp_vld_d;
            rsp_pc_q  <= rsp_pc_d;
            if_id_q   <= if_id_d;
        end
    end

    assign imem_addr      = pc_q;
    assign imem_rd_en     = issue_c;
    assign pc             = pc_q;
    assign if_id_instr    = if_id_q.instr;
    assign if_id_pc_plus1 = if_id_q.pc_plus1;
    assign if_id_valid    = if_id_q.valid;
    assign fetch_halted   = (state_q == HALTED);

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage with a synchronous-read instruction memory model.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic [15:0] imem_addr;
    logic        imem_rd_en;
    logic [15:0] imem_rdata;
    logic [15:0] if_id_instr;
    logic [15:0] if_id_pc_plus1;
    logic        if_id_valid;
    logic [15:0] pc;
    logic        fetch_halted;

    logic [15:0] mem [0:65535];

    int total  = 0;
    int passed = 0;
    int failed = 0;

    always #5 clk = ~clk;

    if_stage dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall          (stall),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .imem_addr      (imem_addr),
        .imem_rd_en     (imem_rd_en),
        .imem_rdata     (imem_rdata),
        .if_id_instr    (if_id_instr),
        .if_id_pc_plus1 (if_id_pc_plus1),
        .if_id_valid    (if_id_valid),
        .pc             (pc),
        .fetch_halted   (fetch_halted)
    );

    // Synchronous-read memory: data appears one cycle after the read is issued.
    always @(posedge clk) begin
        if (imem_rd_en) imem_rdata <= mem[imem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_ifid(input string tag, input logic [15:0] instr,
                            input logic [15:0] pp1, input logic vld);
        chk({tag, ".instr"}, 32'(if_id_instr), 32'(instr));
        chk({tag, ".pp1"},   32'(if_id_pc_plus1), 32'(pp1));
        chk({tag, ".valid"}, 32'(if_id_valid), 32'(vld));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 16'h0000;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = {4'h1, 12'(i)};

        // Reset values while held in reset
        rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 16'h0000;
        #2;
        chk("rst.pc", 32'(pc), 32'h0000);
        chk_ifid("rst", 16'h0000, 16'h0000, 1'b0);
        chk("rst.halted", 32'(fetch_halted), 32'h0);
        chk("rst.rd_en", 32'(imem_rd_en), 32'h1);

        // Linear program 0x0000..0x0004
        do_reset();
        step();
        chk("lin.e1.valid", 32'(if_id_valid), 32'h0);
        chk("lin.e1.pc", 32'(pc), 32'h0001);
        step(); chk_ifid("lin.e2", 16'h1000, 16'h0001, 1'b1);
        step(); chk_ifid("lin.e3", 16'h1001, 16'h0002, 1'b1);
        step(); chk_ifid("lin.e4", 16'h1002, 16'h0003, 1'b1);
        step(); chk_ifid("lin.e5", 16'h1003, 16'h0004, 1'b1);
        step(); chk_ifid("lin.e6", 16'h1004, 16'h0005, 1'b1);

        // Stall for 3 cycles with @0x0002 in flight
        do_reset();
        step(); step(); step();
        chk_ifid("stl.pre", 16'h1001, 16'h0002, 1'b1);
        stall = 1'b1;
        #1 chk("stl.rd_en", 32'(imem_rd_en), 32'h0);
        step(); chk_ifid("stl.h1", 16'h1001, 16'h0002, 1'b1); chk("stl.h1.pc", 32'(pc), 32'h0003);
        step(); chk_ifid("stl.h2", 16'h1001, 16'h0002, 1'b1);
        step(); chk_ifid("stl.h3", 16'h1001, 16'h0002, 1'b1); chk("stl.h3.pc", 32'(pc), 32'h0003);
        stall = 1'b0;
        step(); chk_ifid("stl.r1", 16'h1002, 16'h0003, 1'b1); chk("stl.r1.pc", 32'(pc), 32'h0004);
        step(); chk_ifid("stl.r2", 16'h1003, 16'h0004, 1'b1);

        // Redirect to 0x0040 with @0x0005 in flight
        step(); chk_ifid("rdr.pre", 16'h1004, 16'h0005, 1'b1);
        redirect = 1'b1; redirect_pc = 16'h0040;
        #1 chk("rdr.rd_en", 32'(imem_rd_en), 32'h0);
        step(); chk("rdr.b1.valid", 32'(if_id_valid), 32'h0); chk("rdr.b1.instr", 32'(if_id_instr), 32'h0000);
        chk("rdr.b1.pc", 32'(pc), 32'h0040);
        redirect = 1'b0;
        step(); chk("rdr.b2.valid", 32'(if_id_valid), 32'h0);
        step(); chk_ifid("rdr.tgt", 16'h1040, 16'h0041, 1'b1);
        step(); chk_ifid("rdr.tgt1", 16'h1041, 16'h0042, 1'b1);

        // HLT at 0x0003 stops fetch; redirect resumes
        mem[3] = 16'hF000;
        do_reset();
        repeat (4) step();
        step();
        chk_ifid("hlt.load", 16'hF000, 16'h0004, 1'b1);
        chk("hlt.halted", 32'(fetch_halted), 32'h1);
        chk("hlt.rd_en", 32'(imem_rd_en), 32'h0);
        step(); step();
        chk("hlt.e7.halted", 32'(fetch_halted), 32'h1);
        chk("hlt.e7.rd_en", 32'(imem_rd_en), 32'h0);
        chk("hlt.e7.valid", 32'(if_id_valid), 32'h0);
        chk("hlt.e7.pc", 32'(pc), 32'h0005);
        redirect = 1'b1; redirect_pc = 16'h0010;
        step();
        redirect = 1'b0;
        #1;
        chk("hlt.res.halted", 32'(fetch_halted), 32'h0);
        chk("hlt.res.rd_en", 32'(imem_rd_en), 32'h1);
        chk("hlt.res.pc", 32'(pc), 32'h0010);
        step(); step(); chk_ifid("hlt.res.tgt", 16'h1010, 16'h0011, 1'b1);

        // Wrong-path HLT at 0x0013 squashed by redirect to 0x0030
        mem[16'h0013] = 16'hF000;
        step(); step();
        chk_ifid("wph.pre", 16'h1012, 16'h0013, 1'b1);
        redirect = 1'b1; redirect_pc = 16'h0030;
        step();
        redirect = 1'b0;
        chk("wph.b.valid", 32'(if_id_valid), 32'h0);
        chk("wph.b.halted", 32'(fetch_halted), 32'h0);
        step(); chk("wph.e2.halted", 32'(fetch_halted), 32'h0);
        step(); chk_ifid("wph.tgt", 16'h1030, 16'h0031, 1'b1);

        // PC wrap 0xFFFF -> 0x0000
        redirect = 1'b1; redirect_pc = 16'hFFFF;
        step();
        redirect = 1'b0;
        chk("wrap.pc0", 32'(pc), 32'hFFFF);
        step(); chk("wrap.pc1", 32'(pc), 32'h0000);
        step(); chk_ifid("wrap.top", 16'h1FFF, 16'h0000, 1'b1);
        step(); chk_ifid("wrap.zero", 16'h1000, 16'h0001, 1'b1);

        // Stall and redirect together: redirect wins
        stall = 1'b1; redirect = 1'b1; redirect_pc = 16'h0050;
        step();
        stall = 1'b0; redirect = 1'b0;
        chk("sr.pc", 32'(pc), 32'h0050);
        chk("sr.valid", 32'(if_id_valid), 32'h0);
        step(); step(); chk_ifid("sr.tgt", 16'h1050, 16'h0051, 1'b1);

        // Async reset during stall with skid full
        stall = 1'b1;
        step(); chk_ifid("rs.hold", 16'h1050, 16'h0051, 1'b1);
        #1 rst_n = 1'b0; stall = 1'b0;
        #1;
        chk("rs.pc", 32'(pc), 32'h0000);
        chk_ifid("rs", 16'h0000, 16'h0000, 1'b0);
        chk("rs.halted", 32'(fetch_halted), 32'h0);
        chk("rs.rd_en", 32'(imem_rd_en), 32'h1);
        @(negedge clk); rst_n = 1'b1;
        step(); chk("rs.e1.valid", 32'(if_id_valid), 32'h0);
        step(); chk_ifid("rs.e2", 16'h1000, 16'h0001, 1'b1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
